// File: rtl/branch_predictor_bht_pkg.sv
// Shared types, counter helpers and configuration checks for the BHT/BTB predictor.
package bp_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned IDX_W_DEF  = 6;
  localparam int unsigned CTR_W_DEF  = 2;
  localparam int unsigned TAG_W_DEF  = 8;
  localparam int unsigned CNT_W_DEF  = 32;
  localparam int unsigned CTR_W_MAX  = 4;

  typedef logic [CTR_W_MAX-1:0] ctr_t;

  typedef struct packed {
    logic                  valid;
    logic [TAG_W_DEF-1:0]  tag;
    logic [CTR_W_DEF-1:0]  ctr;
    logic [ADDR_W_DEF-1:0] target;
  } bp_entry_t;

  // Counters are carried at the widest legal width and truncated by the user.
  function automatic ctr_t ctr_init_nt(int unsigned w);
    return ctr_t'((1 << (w - 1)) - 1);
  endfunction

  function automatic ctr_t ctr_weak_t(int unsigned w);
    return ctr_t'(1 << (w - 1));
  endfunction

  function automatic ctr_t ctr_next(ctr_t ctr, logic taken, int unsigned w);
    ctr_t max_v;
    max_v = ctr_t'((1 << w) - 1);
    if (taken)
      return (ctr == max_v) ? ctr : ctr + 1'b1;
    return (ctr == '0) ? ctr : ctr - 1'b1;
  endfunction

  function automatic bit ctr_w_legal(int unsigned w);
    return (w >= 1) && (w <= CTR_W_MAX);
  endfunction

  function automatic bit pc_split_legal(int unsigned addr_w, int unsigned idx_w, int unsigned tag_w);
    return (idx_w + tag_w + 2) <= addr_w;
  endfunction

endpackage

// File: rtl/branch_predictor_bht_if.sv
// Fetch-side prediction and resolve-side update bundle for the branch predictor.
interface branch_predictor_bht_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              mispredict;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  mis_count;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    input  pred_hit, pred_taken, pred_target, mispredict, br_count, mis_count
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_pred_taken, upd_pred_target,
    output pred_hit, pred_taken, pred_target, mispredict, br_count, mis_count
  );
endinterface

// File: rtl/branch_predictor_bht_sat_counter.sv
// One saturating up/down direction counter; reset is weakly not-taken, load is weakly taken.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic             load,
  input  logic             taken,
  output logic [CTR_W-1:0] ctr
);

  ctr_t ctr_wide;
  assign ctr_wide = ctr_t'(ctr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ctr <= CTR_W'(ctr_init_nt(CTR_W));
    else if (load)
      ctr <= CTR_W'(ctr_weak_t(CTR_W));
    else if (inc_en)
      ctr <= CTR_W'(ctr_next(ctr_wide, taken, CTR_W));
  end

endmodule

// File: rtl/branch_predictor_bht.sv
// Direct-mapped BHT + tagged BTB: same-cycle prediction for fetch, learning from resolved branches.
module branch_predictor_bht
  import bp_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned IDX_W  = IDX_W_DEF,
  parameter int unsigned CTR_W  = CTR_W_DEF,
  parameter int unsigned TAG_W  = TAG_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_predictor_bht_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << IDX_W;

  if (!ctr_w_legal(CTR_W)) begin : g_bad_ctr_w
    $error("CTR_W must be in 1..4");
  end
  if (!pc_split_legal(ADDR_W, IDX_W, TAG_W)) begin : g_bad_split
    $error("IDX_W + TAG_W + 2 exceeds ADDR_W");
  end

  // Flop-based table so the whole thing clears on asynchronous reset.
  logic [DEPTH-1:0]              valid_q;
  logic [DEPTH-1:0][TAG_W-1:0]   tag_q;
  logic [DEPTH-1:0][ADDR_W-1:0]  target_q;
  logic [DEPTH-1:0][CTR_W-1:0]   ctr_q;

  logic [IDX_W-1:0] pidx, uidx;
  logic [TAG_W-1:0] ptag, utag;
  logic             uhit, alloc, cnt_en, mis_cond;
  logic             mispredict_q;
  logic [CNT_W-1:0] br_count_q, mis_count_q;
  logic             unused_pc_bits;

  assign pidx = bus.if_pc[IDX_W+1:2];
  assign ptag = bus.if_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign uidx = bus.upd_pc[IDX_W+1:2];
  assign utag = bus.upd_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc_bits = ^{bus.if_pc, bus.upd_pc};

  assign bus.pred_hit    = valid_q[pidx] && (tag_q[pidx] == ptag);
  assign bus.pred_taken  = bus.pred_hit && ctr_q[pidx][CTR_W-1];
  assign bus.pred_target = bus.pred_taken ? target_q[pidx] : bus.if_pc + ADDR_W'(4);

  assign uhit   = valid_q[uidx] && (tag_q[uidx] == utag);
  assign alloc  = bus.upd_valid && !uhit && bus.upd_taken;
  assign cnt_en = bus.upd_valid && uhit;

  assign mis_cond = (bus.upd_taken != bus.upd_pred_taken) ||
                    (bus.upd_taken && bus.upd_pred_taken && (bus.upd_target != bus.upd_pred_target));

  for (genvar i = 0; i < DEPTH; i++) begin : g_ctr
    bp_sat_counter #(.CTR_W(CTR_W)) u_ctr (
      .clk    (clk),
      .rst_n  (rst_n),
      .inc_en (cnt_en && (uidx == IDX_W'(i))),
      .load   (alloc && (uidx == IDX_W'(i))),
      .taken  (bus.upd_taken),
      .ctr    (ctr_q[i])
    );
  end

  // A taken outcome always refreshes the target, whether it hit or allocated.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= '0;
      tag_q    <= '0;
      target_q <= '0;
    end else if (bus.upd_valid) begin
      if (alloc) begin
        valid_q[uidx] <= 1'b1;
        tag_q[uidx]   <= utag;
      end
      if (bus.upd_taken)
        target_q[uidx] <= bus.upd_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mispredict_q <= 1'b0;
      br_count_q   <= '0;
      mis_count_q  <= '0;
    end else begin
      mispredict_q <= bus.upd_valid && mis_cond;
      if (bus.upd_valid && (br_count_q != '1))
        br_count_q <= br_count_q + 1'b1;
      if (bus.upd_valid && mis_cond && (mis_count_q != '1))
        mis_count_q <= mis_count_q + 1'b1;
    end
  end

  assign bus.mispredict = mispredict_q;
  assign bus.br_count   = br_count_q;
  assign bus.mis_count  = mis_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench: 2-bit, 1-bit and narrow-statistics predictors driven by one shared stimulus.
module tb_branch_predictor_bht;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] pc = '0, upc = '0, utgt = '0, uptgt = '0;
  logic        uv = 1'b0, utk = 1'b0, uptk = 1'b0;

  branch_predictor_bht_if #(.ADDR_W(32), .CNT_W(32)) bus0 ();
  branch_predictor_bht_if #(.ADDR_W(32), .CNT_W(32)) bus1 ();
  branch_predictor_bht_if #(.ADDR_W(32), .CNT_W(4))  bus2 ();

  assign bus0.if_pc = pc;   assign bus1.if_pc = pc;   assign bus2.if_pc = pc;
  assign bus0.upd_valid = uv;   assign bus1.upd_valid = uv;   assign bus2.upd_valid = uv;
  assign bus0.upd_pc = upc;   assign bus1.upd_pc = upc;   assign bus2.upd_pc = upc;
  assign bus0.upd_taken = utk;   assign bus1.upd_taken = utk;   assign bus2.upd_taken = utk;
  assign bus0.upd_target = utgt;   assign bus1.upd_target = utgt;   assign bus2.upd_target = utgt;
  assign bus0.upd_pred_taken = uptk;   assign bus1.upd_pred_taken = uptk;   assign bus2.upd_pred_taken = uptk;
  assign bus0.upd_pred_target = uptgt; assign bus1.upd_pred_target = uptgt; assign bus2.upd_pred_target = uptgt;

  branch_predictor_bht #(.CTR_W(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  branch_predictor_bht #(.CTR_W(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  branch_predictor_bht #(.CTR_W(2), .CNT_W(4)) u_dutc (.clk(clk), .rst_n(rst_n), .bus(bus2));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [31:0] p, input logic t, input logic [31:0] tg,
                     input logic pt, input logic [31:0] ptg);
    upc = p; utk = t; utgt = tg; uptk = pt; uptgt = ptg; uv = 1'b1;
    @(posedge clk); #1;
    uv = 1'b0;
  endtask

  task automatic pred0(input string tag, input logic [31:0] p, input logic h, input logic t,
                       input logic [31:0] tg);
    pc = p; #1;
    chk({tag, "_hit"}, 64'(bus0.pred_hit), 64'(h));
    chk({tag, "_taken"}, 64'(bus0.pred_taken), 64'(t));
    chk({tag, "_target"}, 64'(bus0.pred_target), 64'(tg));
  endtask

  initial begin
    pc = 32'h0040_0010;
    #3;
    pred0("rst", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    chk("rst_br", 64'(bus0.br_count), 64'd0);
    chk("rst_mis", 64'(bus0.mis_count), 64'd0);
    chk("rst_mp", 64'(bus0.mispredict), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Allocation of a taken branch that was predicted not-taken.
    upd(32'h0040_0010, 1'b1, 32'h0040_0000, 1'b0, 32'h0040_0014);
    chk("alloc_mp", 64'(bus0.mispredict), 64'd1);
    chk("alloc_mis", 64'(bus0.mis_count), 64'd1);
    chk("alloc_br", 64'(bus0.br_count), 64'd1);
    pred0("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0000);
    chk("alloc_c1_taken", 64'(bus1.pred_taken), 64'd1);

    for (int i = 0; i < 3; i++)
      upd(32'h0040_0010, 1'b1, 32'h0040_0000, 1'b1, 32'h0040_0000);
    chk("ok_mp", 64'(bus0.mispredict), 64'd0);

    // Counter at 3: one not-taken keeps 2-bit taken, flips 1-bit.
    upd(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0000);
    chk("nt1_mp", 64'(bus0.mispredict), 64'd1);
    pred0("nt1", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0000);
    chk("nt1_c1_hit", 64'(bus1.pred_hit), 64'd1);
    chk("nt1_c1_taken", 64'(bus1.pred_taken), 64'd0);
    chk("nt1_c1_target", 64'(bus1.pred_target), 64'h0040_0014);

    upd(32'h0040_0010, 1'b0, 32'h0, 1'b1, 32'h0040_0000);
    pred0("nt2", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);

    // Both taken but wrong target still counts as a mispredict.
    upd(32'h0040_0010, 1'b1, 32'h0040_0000, 1'b1, 32'h0040_0044);
    chk("tgt_mp", 64'(bus0.mispredict), 64'd1);
    chk("tgt_br", 64'(bus0.br_count), 64'd7);
    chk("tgt_mis", 64'(bus0.mis_count), 64'd4);
    pred0("tgt", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0000);

    upd(32'h0040_0110, 1'b1, 32'h0040_0200, 1'b0, 32'h0040_0114);
    pred0("alias_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    pred0("alias_new", 32'h0040_0110, 1'b1, 1'b1, 32'h0040_0200);

    // Miss and not-taken leaves the table alone.
    upd(32'h0040_0010, 1'b0, 32'h0, 1'b0, 32'h0040_0014);
    chk("mnt_mp", 64'(bus0.mispredict), 64'd0);
    pred0("mnt_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
    pred0("mnt_new", 32'h0040_0110, 1'b1, 1'b1, 32'h0040_0200);
    chk("mnt_br", 64'(bus0.br_count), 64'd9);
    chk("mnt_mis", 64'(bus0.mis_count), 64'd5);

    // Same-cycle predict and update at one index: old counter first.
    pc = 32'h0040_0110; upc = 32'h0040_0110; utk = 1'b0; utgt = '0;
    uptk = 1'b1; uptgt = 32'h0040_0200; uv = 1'b1;
    #1;
    chk("same_pre_taken", 64'(bus0.pred_taken), 64'd1);
    chk("same_pre_target", 64'(bus0.pred_target), 64'h0040_0200);
    @(posedge clk); #1;
    uv = 1'b0;
    pred0("same_post", 32'h0040_0110, 1'b1, 1'b0, 32'h0040_0114);

    pred0("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

    // 20 mispredicting miss/not-taken updates saturate the 4-bit counters.
    for (int i = 0; i < 20; i++)
      upd(32'h0040_0800, 1'b0, 32'h0, 1'b1, 32'h0040_0900);
    chk("sat_br", 64'(bus2.br_count), 64'd15);
    chk("sat_mis", 64'(bus2.mis_count), 64'd15);
    chk("wide_br", 64'(bus0.br_count), 64'd30);
    chk("wide_mis", 64'(bus0.mis_count), 64'd26);
    upd(32'h0040_0800, 1'b0, 32'h0, 1'b1, 32'h0040_0900);
    chk("sat_hold_br", 64'(bus2.br_count), 64'd15);
    chk("sat_hold_mis", 64'(bus2.mis_count), 64'd15);
    chk("pre_rst_mp", 64'(bus0.mispredict), 64'd1);

    // Asynchronous reset mid-cycle clears everything immediately.
    pc = 32'h0040_0110;
    #2; rst_n = 1'b0; #1;
    chk("mrst_hit", 64'(bus0.pred_hit), 64'd0);
    chk("mrst_taken", 64'(bus0.pred_taken), 64'd0);
    chk("mrst_target", 64'(bus0.pred_target), 64'h0040_0114);
    chk("mrst_br", 64'(bus0.br_count), 64'd0);
    chk("mrst_mis", 64'(bus0.mis_count), 64'd0);
    chk("mrst_mp", 64'(bus0.mispredict), 64'd0);
    chk("mrst_c_br", 64'(bus2.br_count), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_hit", 64'(bus0.pred_hit), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Parametrised dynamic branch predictor for the IF stage of the MIPS pipeline: a direct-mapped table of N-bit saturating counters plus a tagged branch target buffer (BTB), indexed by low PC bits. It supplies a same-cycle taken/target prediction to the fetch mux. It learns from resolved branches reported by the stage that computes the outcome. CTR_W=1 gives the classic 1-bit predictor; CTR_W=2 gives the 2-bit hysteresis predictor; the BTB removes the taken-branch target penalty.

## Interface
- ADDR_W, 32, PC width
- IDX_W, 6, index bits; table depth 2^IDX_W
- CTR_W, 2, counter width, legal 1..4
- TAG_W, 8, BTB tag bits; IDX_W+TAG_W+2 <= ADDR_W
- CNT_W, 32, statistics counter width

- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- if_pc  in  ADDR_W  PC being fetched
- pred_hit  out  1  BTB entry valid and tag match for if_pc
- pred_taken  out  1  predicted taken (only when pred_hit)
- pred_target  out  ADDR_W  predicted next PC
- upd_valid  in  1  one resolved branch this cycle
- upd_pc  in  ADDR_W  PC of resolved branch
- upd_taken  in  1  actual outcome
- upd_target  in  ADDR_W  actual taken target
- upd_pred_taken  in  1  prediction made for this branch, carried down the pipe
- upd_pred_target  in  ADDR_W  predicted target, carried down the pipe
- mispredict  out  1  registered; high one cycle after an update that mispredicted
- br_count  out  CNT_W  resolved branches since reset
- mis_count  out  CNT_W  mispredictions since reset

## Operation
- Index = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]; pc[1:0] ignored.
- Entry holds: valid, tag, ctr[CTR_W-1:0], target[ADDR_W-1:0].
- Prediction: pred_hit = valid & tag match; pred_taken = pred_hit & ctr[CTR_W-1]; pred_target = pred_taken ? entry.target : if_pc+4 (wraps modulo 2^ADDR_W).
- Update when upd_valid:
  - On a hit, the counter moves toward the outcome: +1 on taken, saturating at 2^CTR_W-1; -1 on not-taken, saturating at 0. The target is written only when the outcome is taken.
  - Miss and taken: allocate. Set valid=1, write the tag and target, ctr = 2^(CTR_W-1) (weakly taken). This overwrites any aliasing entry.
  - Miss and not-taken: no table change.
- Mispredict condition: upd_taken != upd_pred_taken, or both taken with upd_target != upd_pred_target.
- Statistics: br_count +1 per upd_valid; mis_count +1 per mispredict. Both saturate at all-ones and never wrap.
- No flush input. Squashed wrong-path branches must not assert upd_valid.

## Timing
- Prediction is combinational from table state; zero latency.
- Updates are written at the clock edge and are visible to prediction the following cycle.
- Same-cycle update and predict to the same index: the prediction uses the pre-update entry. There is no bypass.
- mispredict, br_count and mis_count are registered, one cycle after upd_valid.
- Reset, including mid-operation:
  - all valid=0
  - every ctr = 2^(CTR_W-1)-1 (weakly not-taken; 0 for CTR_W=1)
  - every target=0
  - br_count=0, mis_count=0, mispredict=0
  - with valid=0, outputs read pred_hit=0, pred_taken=0, pred_target=if_pc+4
- The table is built from flops, not inferred RAM, because it needs a full asynchronous reset.

## Structure
- Package bp_pkg holds:
  - counter helper functions: ctr_init_nt, ctr_weak_t, ctr_next(ctr, taken)
  - an entry struct typedef parametrised through localparams
  - the legal-range checks for CTR_W and for IDX_W+TAG_W+2 <= ADDR_W (elaboration asserts)
- Sub-module bp_sat_counter: one CTR_W-bit saturating up/down counter with load. It is instantiated 2^IDX_W times by a generate loop.
- Statistics counters live in the top module.

## Test plan
- Reset, then if_pc=0x0040_0010 -> pred_hit=0, pred_taken=0, pred_target=0x0040_0014; br_count=0.
- Update pc=0x0040_0010, taken, target=0x0040_0000, upd_pred_taken=0 -> next cycle mispredict=1, mis_count=1. Predicting the same PC then gives hit=1, taken=1, target=0x0040_0000.
- CTR_W=2 loop: 4 taken updates, then 1 not-taken -> still predicts taken. A second not-taken -> predicts not-taken. With CTR_W=1, a single not-taken flips it.
- Alias: PCs 0x0040_0010 and 0x0040_0110 (same index, different tag). Allocating the second makes the first miss (pred_hit=0, pred_target=pc+4).
- Same-cycle update and predict at one index: prediction shows the old counter; the next cycle shows the new one. Assert rst_n mid-stream -> all outputs return to reset values immediately.
- Force CNT_W=4 and issue 20 mispredicting updates -> br_count=mis_count=15 and holds.
